instr_queue_register: RTL and testbench

- Parametrised successor to the microprogrammed CPU's instruction register.
- Buffers fetched words in a DEPTH-entry FIFO with a valid/ready handshake.
- Loads the IR on i_il and decodes its fields, including two-word "extended" instructions whose second word is a full-width immediate.
- Sits between the memory fetch path and the control-word/datapath decode.

---
 rtl/instr_queue_register.sv | 161 ++++++++++++++++
 tb/tb_instr_queue_register.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_queue_register.sv
// Instruction queue + instruction register. Fetched words are buffered in a
// DEPTH-entry FIFO and loaded into the IR on i_il. If bit IW-1 of a loaded word
// is set, the instruction has two words, and the next word is a full-width
// immediate.
module instr_queue_register #(
  parameter int IW    = 32,
  parameter int DEPTH = 4,
  parameter int REG_W = 4,
  parameter int OPC_W = 7
) (
  input  logic                        i_clk,
  input  logic                        i_rstn,
  input  logic [IW-1:0]               i_instr,
  input  logic                        i_valid,
  output logic                        o_ready,
  input  logic                        i_il,
  input  logic                        i_flush,
  output logic                        o_stall,
  output logic                        o_ir_valid,
  output logic                        o_ext,
  output logic [IW-2-3*REG_W-OPC_W:0] o_opr,
  output logic [OPC_W-1:0]            o_opcode,
  output logic [4:0]                  o_fs,
  output logic [REG_W-1:0]            o_dr,
  output logic [REG_W-1:0]            o_sa,
  output logic [REG_W-1:0]            o_sb,
  output logic [IW-1:0]               o_imd,
  output logic [$clog2(DEPTH):0]      o_count
);

  localparam int OPR_W = IW - 1 - 3*REG_W - OPC_W;
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = PW + 1;
  localparam int OPR_L = 3*REG_W + OPC_W;

  typedef enum logic {S_IDLE, S_WAIT_IMM} state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q, count_d;
  logic              full, empty, push, pop, load_ir, cap_imm;
  logic [IW-1:0]     head;

  logic              ir_valid_q, ext_q;
  logic [OPR_W-1:0]  opr_q;
  logic [OPC_W-1:0]  opcode_q;
  logic [REG_W-1:0]  dr_q, sa_q, sb_q;
  logic [IW-1:0]     imd_q;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign o_ready = !full;
  assign push    = i_valid && !full && !i_flush;
  assign head    = mem_q[rd_ptr_q];
  assign pop     = load_ir || cap_imm;

  // Next state, IR load / immediate capture decisions and stall.
  always_comb begin
    state_d = state_q;
    load_ir = 1'b0;
    cap_imm = 1'b0;
    o_stall = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_il) begin
          if (empty) begin
            o_stall = 1'b1;
          end else if (!i_flush) begin
            load_ir = 1'b1;
            if (head[IW-1]) state_d = S_WAIT_IMM;
          end
        end
      end
      S_WAIT_IMM: begin
        if (!empty && !i_flush) begin
          cap_imm = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (i_flush) state_d = S_IDLE;
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Occupancy after this cycle's push/pop; flush empties the queue.
  always_comb begin
    count_d = count_q + CW'(push) - CW'(pop);
    if (i_flush) count_d = '0;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (i_flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  // FIFO storage; contents are only meaningful behind the pointers.
  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= i_instr;
  end

  // IR fields and immediate; an extended load leaves o_imd for the second word.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      ir_valid_q <= 1'b0;
      ext_q      <= 1'b0;
      opr_q      <= '0;
      opcode_q   <= '0;
      dr_q       <= '0;
      sa_q       <= '0;
      sb_q       <= '0;
      imd_q      <= '0;
    end else if (i_flush) begin
      ir_valid_q <= 1'b0;
    end else if (load_ir) begin
      ext_q      <= head[IW-1];
      opr_q      <= head[IW-2:OPR_L];
      opcode_q   <= head[OPR_L-1:3*REG_W];
      dr_q       <= head[3*REG_W-1:2*REG_W];
      sa_q       <= head[2*REG_W-1:REG_W];
      sb_q       <= head[REG_W-1:0];
      ir_valid_q <= !head[IW-1];
      if (!head[IW-1])
        imd_q <= {{(IW-OPR_W-REG_W){1'b0}}, head[IW-2:OPR_L], head[REG_W-1:0]};
    end else if (cap_imm) begin
      imd_q      <= head;
      ir_valid_q <= 1'b1;
    end
  end

  assign o_ir_valid = ir_valid_q;
  assign o_ext      = ext_q;
  assign o_opr      = opr_q;
  assign o_opcode   = opcode_q;
  assign o_fs       = opcode_q[4:0];
  assign o_dr       = dr_q;
  assign o_sa       = sa_q;
  assign o_sb       = sb_q;
  assign o_imd      = imd_q;
  assign o_count    = count_q;

endmodule

// File: tb/tb_instr_queue_register.sv
// Bench for instr_queue_register: directed scenarios plus random traffic,
// checked against a queue-based reference model.
module tb_instr_queue_register;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] instr;
  logic        valid, il, flush;
  logic        o_ready, o_stall, o_ir_valid, o_ext;
  logic [11:0] o_opr;
  logic [6:0]  o_opcode;
  logic [4:0]  o_fs;
  logic [3:0]  o_dr, o_sa, o_sb;
  logic [31:0] o_imd;
  logic [2:0]  o_count;

  always #5 clk = ~clk;

  instr_queue_register #(.IW(32), .DEPTH(DEPTH), .REG_W(4), .OPC_W(7)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_instr(instr), .i_valid(valid),
    .o_ready(o_ready), .i_il(il), .i_flush(flush), .o_stall(o_stall),
    .o_ir_valid(o_ir_valid), .o_ext(o_ext), .o_opr(o_opr), .o_opcode(o_opcode),
    .o_fs(o_fs), .o_dr(o_dr), .o_sa(o_sa), .o_sb(o_sb), .o_imd(o_imd),
    .o_count(o_count)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference model: the queue contents plus the architectural IR state.
  logic [31:0] q[$];
  bit          m_wait;
  bit          m_irv, m_ext;
  int unsigned m_opr, m_opc, m_dr, m_sa, m_sb;
  logic [31:0] m_imd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_wait = 0; m_irv = 0; m_ext = 0;
    m_opr = 0; m_opc = 0; m_dr = 0; m_sa = 0; m_sb = 0;
    m_imd = '0;
  endtask

  task automatic check_regs();
    check("ir_valid", o_ir_valid, m_irv);
    check("ext",      o_ext,      m_ext);
    check("opr",      o_opr,      m_opr);
    check("opcode",   o_opcode,   m_opc);
    check("fs",       o_fs,       m_opc % 32);
    check("dr",       o_dr,       m_dr);
    check("sa",       o_sa,       m_sa);
    check("sb",       o_sb,       m_sb);
    check("count",    o_count,    q.size());
    if (m_irv) check("imd", o_imd, m_imd);
  endtask

  // One clock cycle: drive on the falling edge, check combinational outputs,
  // advance the model, then check registered outputs just after the rising edge.
  task automatic step(input bit v, input logic [31:0] w, input bit l, input bit f);
    bit          rdy;
    logic [31:0] h;
    @(negedge clk);
    valid = v; instr = w; il = l; flush = f;
    #1;
    rdy = (q.size() < DEPTH);
    check("ready", o_ready, rdy);
    check("stall", o_stall, l && (q.size() == 0) && !m_wait);
    check("count_pre", o_count, q.size());
    if (f) begin
      q.delete();
      m_wait = 0;
      m_irv  = 0;
    end else begin
      if (m_wait) begin
        if (q.size() > 0) begin
          m_imd  = q.pop_front();
          m_irv  = 1;
          m_wait = 0;
        end
      end else if (l && q.size() > 0) begin
        h      = q.pop_front();
        m_ext  = (h >> 31) != 0;
        m_opr  = (h >> 19) % 4096;
        m_opc  = (h >> 12) % 128;
        m_dr   = (h >> 8) % 16;
        m_sa   = (h >> 4) % 16;
        m_sb   = h % 16;
        m_irv  = !m_ext;
        m_wait = m_ext;
        if (!m_ext) m_imd = m_opr * 16 + m_sb;
      end
      if (v && rdy) q.push_back(w);
    end
    @(posedge clk);
    #1;
    check_regs();
  endtask

  // Asynchronous reset asserted between clock edges.
  task automatic do_reset();
    @(negedge clk);
    valid = 0; il = 0; flush = 0; instr = '0;
    #2 rstn = 1'b0;
    #1;
    model_reset();
    check_regs();
    check("imd_rst", o_imd, 32'h0);
    check("ready_rst", o_ready, 1'b1);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    rstn = 1'b0; valid = 0; il = 0; flush = 0; instr = '0;
    model_reset();
    do_reset();

    // Single-word instruction decode.
    step(1, 32'h0012_3456, 0, 0);
    step(0, 32'h0, 1, 0);
    check("t1_ext", o_ext, 1'b0);
    check("t1_opcode", o_opcode, 7'h23);
    check("t1_fs", o_fs, 5'h03);
    check("t1_dr", o_dr, 4'h4);
    check("t1_sa", o_sa, 4'h5);
    check("t1_sb", o_sb, 4'h6);
    check("t1_opr", o_opr, 12'h002);
    check("t1_imd", o_imd, 32'h0000_0026);
    check("t1_valid", o_ir_valid, 1'b1);
    check("t1_count", o_count, 3'd0);

    // Extended instruction with its immediate already queued.
    step(1, 32'h8003_0000, 0, 0);
    step(1, 32'hDEAD_BEEF, 1, 0);
    check("t2_ext", o_ext, 1'b1);
    check("t2_valid0", o_ir_valid, 1'b0);
    step(0, 32'h0, 0, 0);
    check("t2_imd", o_imd, 32'hDEAD_BEEF);
    check("t2_valid1", o_ir_valid, 1'b1);
    check("t2_count", o_count, 3'd0);

    // Immediate arrives late; i_il ignored while waiting.
    step(1, 32'h8123_4567, 0, 0);
    step(0, 32'h0, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 32'h0, 1, 0);
    check("t3_wait_valid", o_ir_valid, 1'b0);
    step(1, 32'hCAFE_F00D, 0, 0);
    step(0, 32'h0, 0, 0);
    check("t3_imd", o_imd, 32'hCAFE_F00D);
    check("t3_valid", o_ir_valid, 1'b1);

    // Fill to full, drain in order, then wrap with push/pop pairs.
    for (int i = 0; i < 5; i++) step(1, 32'h0100_0000 + 32'h111 * i, 0, 0);
    check("t4_ready", o_ready, 1'b0);
    check("t4_count", o_count, 3'd4);
    for (int i = 0; i < 4; i++) step(0, 32'h0, 1, 0);
    step(1, 32'h0200_0ABC, 1, 0);
    check("t4_simul_count", o_count, 3'd1);
    for (int i = 0; i < 5; i++) step(1, 32'h0300_0000 + 32'h1357 * i, 1, 0);
    step(0, 32'h0, 1, 0);

    // Empty FIFO stall.
    step(0, 32'h0, 1, 0);
    check("t5_count", o_count, 3'd0);

    // Flush while waiting for an immediate with entries queued.
    step(1, 32'h8000_1234, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 32'h0400_0000 + i, 0, 0);
    step(0, 32'h0, 1, 0);
    check("t6_count_pre", o_count, 3'd3);
    step(1, 32'h0500_0000, 0, 1);
    check("t6_count", o_count, 3'd0);
    check("t6_valid", o_ir_valid, 1'b0);
    step(0, 32'h0, 1, 0);
    check("t6_count_post", o_count, 3'd0);

    // Reset in the middle of a two-word instruction.
    step(1, 32'h8765_4321, 0, 0);
    step(0, 32'h0, 1, 0);
    do_reset();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      else step($urandom_range(0, 2) != 0, $urandom, $urandom_range(0, 1) == 1,
                $urandom_range(0, 15) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
